spi_slave_frame_ctrl: RTL

Frame-level controller that sequences an SPI slave byte engine (serial shifter plus SCLK edge analyser) against a register bank.
- Watches chip select and enables the byte engine for the frame.
- Decodes the first received byte as a command (R/W plus address).
- Then streams write data into the bank, or prefetches read data into the engine's transmit byte, with address auto-increment.
- Sits between the pad-level slave datapath and the register file.

---
 rtl/spi_frame_pkg.sv | 21 ++
 rtl/spi_cs_sync.sv | 43 ++++
 rtl/spi_slave_frame_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI slave frame controller.
// The state encoding and status byte are shared by the controller and any master-side reuse.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RD_LOAD,
    RDATA
  } state_t;

  localparam int         CMD_RW_BIT  = 7;
  localparam logic [7:0] STATUS_BYTE = 8'hA5;

  // Byte counters stick at 255 rather than wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Multi-flop synchroniser for an asynchronous active-low select, with rise/fall pulses.
// Edges are suppressed until the select has been seen inactive after reset.
module spi_cs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_vld;
  logic              r_prev;
  logic              r_armed;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  // r_vld marks when the chain holds real pad samples rather than reset values;
  // arming only on a genuinely high select keeps a select held low through reset from
  // looking like a fresh frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '1;
      r_vld   <= '0;
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_vld  <= {r_vld[STAGES-2:0], 1'b1};
      r_prev <= w_level;
      if (r_vld[STAGES-1] && w_level) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rise = r_armed &  w_level & ~r_prev;
  assign o_fall = r_armed & ~w_level &  r_prev;

endmodule

// File: rtl/spi_slave_frame_ctrl.sv
// Frame-level sequencer between an SPI slave byte engine and a register bank:
// command decode, write streaming, read prefetch and frame bookkeeping.
module spi_slave_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter bit AUTO_INC    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_cs_n_wire,
  output logic              om_work_en,
  input  logic              im_byte_done,
  input  logic [7:0]        im_rx_byte,
  output logic [7:0]        om_tx_byte,
  output logic [ADDR_W-1:0] om_reg_addr,
  output logic              om_reg_wr,
  output logic [7:0]        om_reg_wdata,
  input  logic [7:0]        im_reg_rdata,
  output logic              om_frame_done,
  output logic              om_frame_err,
  output logic [7:0]        om_byte_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = AUTO_INC ? ADDR_W'(1) : '0;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_work_en;
  logic [7:0]        r_tx_byte;
  logic              r_frame_done;
  logic              r_frame_err;
  logic [7:0]        r_byte_cnt;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic              w_wr;

  spi_cs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (im_cs_n_wire),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // The write strobe is combinational so the bank captures the byte in its byte_done cycle.
  assign w_wr = (r_state == WDATA) && im_byte_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_work_en    <= 1'b0;
      r_tx_byte    <= STATUS_BYTE;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_cnt   <= 8'h00;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state    <= CMD;
            r_work_en  <= 1'b1;
            r_byte_cnt <= 8'h00;
            r_tx_byte  <= STATUS_BYTE;
          end
        end
        CMD: begin
          if (im_byte_done) begin
            r_addr     <= im_rx_byte[ADDR_W-1:0];
            r_byte_cnt <= sat_inc8(r_byte_cnt);
            r_state    <= im_rx_byte[CMD_RW_BIT] ? RD_LOAD : WDATA;
          end
        end
        RD_LOAD: begin
          r_tx_byte <= im_reg_rdata;
          r_addr    <= r_addr + ADDR_STEP;
          r_state   <= RDATA;
        end
        RDATA: begin
          if (im_byte_done) begin
            r_byte_cnt <= sat_inc8(r_byte_cnt);
            r_state    <= RD_LOAD;
          end
        end
        WDATA: begin
          if (im_byte_done) begin
            r_addr     <= r_addr + ADDR_STEP;
            r_byte_cnt <= sat_inc8(r_byte_cnt);
          end
        end
        default: r_state <= IDLE;
      endcase
      // A select rise ends the frame after any coincident byte has been taken above;
      // a command byte arriving in the same cycle still makes the frame valid.
      if ((r_state != IDLE) && w_cs_rise) begin
        r_state   <= IDLE;
        r_work_en <= 1'b0;
        r_tx_byte <= STATUS_BYTE;
        if ((r_state == CMD) && !im_byte_done) begin
          r_frame_err <= 1'b1;
        end else begin
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign om_work_en    = r_work_en;
  assign om_tx_byte    = r_tx_byte;
  assign om_reg_addr   = r_addr;
  assign om_reg_wr     = w_wr;
  assign om_reg_wdata  = w_wr ? im_rx_byte : 8'h00;
  assign om_frame_done = r_frame_done;
  assign om_frame_err  = r_frame_err;
  assign om_byte_cnt   = r_byte_cnt;

endmodule
